// File: rtl/ringosc_meter.sv
// Ring-oscillator measurement front end: enables the oscillator, lets it settle, then counts
// synchronized rising edges of its output over a programmable window of reference clocks.
module ringosc_meter #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned WIN_WIDTH  = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIN_WIDTH-1:0] win_len,
    input  logic                 osc_in,
    output logic                 osc_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDone
    } state_e;

    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);

    state_e                 r_state;
    state_e                 w_state_next;

    logic                   r_s1;
    logic                   r_s2;
    logic                   r_s3;
    logic                   w_edge;

    logic [7:0]             r_settle_cnt;
    logic [WIN_WIDTH-1:0]   r_win_len;
    logic [WIN_WIDTH-1:0]   r_win_cnt;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_overflow;

    logic                   w_start_acc;
    logic                   w_settle_end;
    logic                   w_win_last;
    logic                   w_count_en;

    assign w_edge       = r_s2 & ~r_s3;
    assign w_start_acc  = (r_state == StIdle) & start;
    assign w_settle_end = (r_state == StSettle) && (r_settle_cnt == 8'd0);
    // Treat <=1 as the last cycle so a corrupted counter can never stall the FSM.
    assign w_win_last   = (r_state == StMeasure) && (r_win_cnt <= WIN_WIDTH'(1));
    assign w_count_en   = (r_state == StMeasure) & w_edge;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StSettle;
                end
            end
            StSettle: begin
                if (r_settle_cnt == 8'd0) begin
                    w_state_next = (r_win_len == '0) ? StDone : StMeasure;
                end
            end
            StMeasure: begin
                if (w_win_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        osc_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            StIdle: begin
                osc_en = 1'b0;
                busy   = 1'b0;
            end
            StSettle, StMeasure: begin
                osc_en = 1'b1;
                busy   = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                osc_en = 1'b0;
            end
        endcase
    end

    // osc_in is asynchronous to clk; s3 holds history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= osc_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= 8'd0;
        end else if (w_start_acc) begin
            r_settle_cnt <= SettleLoad;
        end else if ((r_state == StSettle) && (r_settle_cnt != 8'd0)) begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_len <= '0;
        end else if (w_start_acc) begin
            r_win_len <= win_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
        end else if (w_settle_end) begin
            r_win_cnt <= r_win_len;
        end else if ((r_state == StMeasure) && (r_win_cnt != '0)) begin
            r_win_cnt <= r_win_cnt - WIN_WIDTH'(1);
        end
    end

    // Saturating edge counter; overflow is sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_acc) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_count_en) begin
            if (&r_count) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
